ob_cn_table: RTL

OB_CN_TABLE -- requirements
Module: ob_cn_table

---
 rtl/ob_cn_table.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ob_cn_table.sv
// rtl/ob_cn_table.sv - conditional (stop) order table: holds stop commands until the book triggers them
package ob_pkg;
    typedef enum logic [3:0] {
        Op_Nop           = 4'd0,
        Op_BuyLimit      = 4'd1,
        Op_SellLimit     = 4'd2,
        Op_BuyMarket     = 4'd3,
        Op_SellMarket    = 4'd4,
        Op_BuyStopLoss   = 4'd5,
        Op_SellStopLoss  = 4'd6,
        Op_BuyStopLimit  = 4'd7,
        Op_SellStopLimit = 4'd8
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [15:0] price;
        logic [15:0] qty;
    } cmd_t;

    typedef struct packed {
        logic [15:0] price;
    } table_t;

    function automatic logic is_stop(opcode_t op);
        return op inside {Op_BuyStopLoss, Op_BuyStopLimit, Op_SellStopLoss, Op_SellStopLimit};
    endfunction

    function automatic logic is_buy_stop(opcode_t op);
        return op inside {Op_BuyStopLoss, Op_BuyStopLimit};
    endfunction

    function automatic opcode_t to_matured(opcode_t op);
        case (op)
            Op_BuyStopLoss:   return Op_BuyMarket;
            Op_SellStopLoss:  return Op_SellMarket;
            Op_BuyStopLimit:  return Op_BuyLimit;
            Op_SellStopLimit: return Op_SellLimit;
            default:          return op;
        endcase
    endfunction
endpackage

module ob_cn_table #(
    parameter int N     = 4,
    parameter int UID_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  ob_pkg::cmd_t           in_cmd,
    input  logic [UID_W-1:0]       in_uid,
    output logic                   in_rdy,
    input  logic                   cancel_vld,
    input  logic [UID_W-1:0]       cancel_uid,
    output logic                   cancel_hit,
    output logic                   err_vld,
    input  logic                   cntrl_evt_texe_r,
    input  logic                   lm_bid_table_vld_r,
    input  ob_pkg::table_t         lm_bid_table_r,
    input  logic                   lm_ask_table_vld_r,
    input  ob_pkg::table_t         lm_ask_table_r,
    output logic                   out_vld,
    output ob_pkg::cmd_t           out_cmd,
    output logic [UID_W-1:0]       out_uid,
    input  logic                   out_rdy,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(N+1)-1:0] count
);
    import ob_pkg::*;

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {E_IDLE, E_ACTIVE, E_MATURED} ent_state_t;

    ent_state_t       state [N];
    cmd_t             cmd_q [N];
    logic [UID_W-1:0] uid_q [N];
    logic [IW-1:0]    ptr;
    logic             lock;
    logic [IW-1:0]    lock_idx;

    logic [N-1:0]     cancel_match;
    logic [N-1:0]     mature;
    logic [N-1:0]     is_mat;
    logic [IW-1:0]    alloc_idx;
    logic [IW-1:0]    rr_sel;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    sel_next;
    logic [CW-1:0]    cnt;
    logic             issue;
    logic             accept;
    logic             do_alloc;
    int               rr_j;

    // Descending loops so the lowest index is the last (winning) assignment.
    always_comb begin
        cancel_match = '0;
        mature       = '0;
        is_mat       = '0;
        alloc_idx    = '0;
        cnt          = '0;
        for (int i = N-1; i >= 0; i--) begin
            cancel_match[i] = cancel_vld && (state[i] == E_ACTIVE) && (uid_q[i] == cancel_uid);
            is_mat[i]       = (state[i] == E_MATURED);
            if (state[i] == E_ACTIVE) begin
                if (is_buy_stop(cmd_q[i].opcode))
                    mature[i] = cntrl_evt_texe_r && lm_bid_table_vld_r &&
                                (cmd_q[i].price <= lm_bid_table_r.price);
                else
                    mature[i] = cntrl_evt_texe_r && lm_ask_table_vld_r &&
                                (cmd_q[i].price >= lm_ask_table_r.price);
            end
            if (state[i] == E_IDLE)
                alloc_idx = IW'(i);
            if (state[i] != E_IDLE)
                cnt = cnt + CW'(1);
        end
    end

    always_comb begin
        rr_sel = ptr;
        rr_j   = 0;
        for (int k = N-1; k >= 0; k--) begin
            rr_j = int'(ptr) + k;
            if (rr_j >= N)
                rr_j = rr_j - N;
            if (state[rr_j] == E_MATURED)
                rr_sel = IW'(rr_j);
        end
    end

    assign count    = cnt;
    assign full     = (cnt == CW'(N));
    assign empty    = (cnt == '0);
    assign in_rdy   = !full;
    assign out_vld  = |is_mat;
    assign sel      = lock ? lock_idx : rr_sel;
    assign out_cmd  = cmd_q[sel];
    assign out_uid  = uid_q[sel];
    assign issue    = out_vld && out_rdy;
    assign accept   = in_vld && in_rdy;
    assign do_alloc = accept && is_stop(in_cmd.opcode);
    assign sel_next = (sel == IW'(N-1)) ? '0 : sel + IW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= E_IDLE;
                cmd_q[i] <= '0;
                uid_q[i] <= '0;
            end
            ptr        <= '0;
            lock       <= 1'b0;
            lock_idx   <= '0;
            cancel_hit <= 1'b0;
            err_vld    <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (state[i])
                    E_IDLE: begin
                        if (do_alloc && (alloc_idx == IW'(i))) begin
                            state[i] <= E_ACTIVE;
                            cmd_q[i] <= in_cmd;
                            uid_q[i] <= in_uid;
                        end
                    end
                    E_ACTIVE: begin
                        if (cancel_match[i])
                            state[i] <= E_IDLE;
                        else if (mature[i]) begin
                            state[i]        <= E_MATURED;
                            cmd_q[i].opcode <= to_matured(cmd_q[i].opcode);
                        end
                    end
                    E_MATURED: begin
                        if (issue && (sel == IW'(i)))
                            state[i] <= E_IDLE;
                    end
                    default: state[i] <= E_IDLE;
                endcase
            end
            if (issue) begin
                lock <= 1'b0;
                ptr  <= sel_next;
            end else if (out_vld) begin
                lock     <= 1'b1;
                lock_idx <= sel;
            end
            cancel_hit <= |cancel_match;
            err_vld    <= accept && !is_stop(in_cmd.opcode);
        end
    end
endmodule
